// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// FSM state encoding, datapath width and iteration count.
package rv32m_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;
    localparam logic [4:0] ITER_LAST = 5'(ITER - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a value that is treated as two's complement when is_signed is set.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply or restoring
// divide over a shared 64-bit working register, then a sign-fix cycle.
module muldiv_unit
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_in,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [4:0]      rd_sel_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_sel_out
);

    // Handshake: a request is taken on any edge where the FSM is IDLE, start_in=1
    // and flush_in=0; the result arrives later as a single-cycle done_out strobe
    // with result_out/rd_sel_out valid. Requests outside IDLE are dropped, not queued.

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_work;
    logic [2*XLEN-1:0] w_work_next;
    logic [4:0]        r_cnt;
    logic              r_neg_a;
    logic              r_neg_b;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd;

    logic              w_accept;
    logic              w_is_div;
    logic              w_s1;
    logic              w_s2;
    logic              w_special;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign w_accept = (r_state == ST_IDLE) && start_in && !flush_in;
    assign w_is_div = op_in[2];

    always_comb begin
        w_s1 = 1'b0;
        w_s2 = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                w_s1 = 1'b1;
                w_s2 = 1'b1;
            end
            OP_MULHSU: w_s1 = 1'b1;
            default: ;
        endcase
    end

    assign w_mag1 = mag(rs1_value_in, w_s1);
    assign w_mag2 = mag(rs2_value_in, w_s2);

    // Divide-by-zero and signed overflow finish without iterating.
    always_comb begin
        w_special        = 1'b0;
        w_special_result = '0;
        if (w_is_div && (rs2_value_in == '0)) begin
            w_special        = 1'b1;
            w_special_result = op_in[1] ? rs1_value_in : '1;
        end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                     (rs1_value_in == 32'h8000_0000) && (rs2_value_in == 32'hFFFF_FFFF)) begin
            w_special        = 1'b1;
            w_special_result = op_in[1] ? '0 : 32'h8000_0000;
        end
    end

    // Multiply adds r_opb into the upper half and shifts right; divide shifts
    // left and subtracts the divisor from the 33-bit partial remainder.
    assign w_sum   = {1'b0, r_work[2*XLEN-1:XLEN]} + (r_work[0] ? {1'b0, r_opb} : '0);
    assign w_trial = r_work[2*XLEN-1:XLEN-1] - {1'b0, r_opb};

    always_comb begin
        w_work_next = r_work;
        if (!r_op[2]) begin
            w_work_next = {w_sum, r_work[XLEN-1:1]};
        end else if (w_trial[XLEN]) begin
            w_work_next = {r_work[2*XLEN-2:0], 1'b0};
        end else begin
            w_work_next = {w_trial[XLEN-1:0], r_work[XLEN-2:0], 1'b1};
        end
    end

    assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_work + 1'b1) : r_work;
    assign w_quot = (r_neg_a ^ r_neg_b) ? (~r_work[XLEN-1:0] + 1'b1) : r_work[XLEN-1:0];
    assign w_rem  = r_neg_a ? (~r_work[2*XLEN-1:XLEN] + 1'b1) : r_work[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix_result = w_quot;
            default:                      w_fix_result = w_rem;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_in)                w_next_state = ST_IDLE;
                else if (r_cnt == ITER_LAST) w_next_state = ST_FIX;
            end
            ST_FIX:  w_next_state = flush_in ? ST_IDLE : ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_opb    <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == ST_CALC) || (w_next_state == ST_FIX);
            r_done  <= (w_next_state == ST_DONE);
            if (w_accept) begin
                r_op    <= op_in;
                r_rd    <= rd_sel_in;
                r_cnt   <= '0;
                r_neg_a <= w_s1 && rs1_value_in[XLEN-1];
                r_neg_b <= w_s2 && rs2_value_in[XLEN-1];
                r_opb   <= w_is_div ? w_mag2 : w_mag1;
                r_work  <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                if (w_special) r_result <= w_special_result;
            end else if (r_state == ST_CALC) begin
                r_work <= w_work_next;
                r_cnt  <= r_cnt + 5'd1;
            end else if (r_state == ST_FIX && !flush_in) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign busy_out   = r_busy;
    assign done_out   = r_done;
    assign result_out = r_result;
    assign rd_sel_out = r_rd;

endmodule
